// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage initiator for a word-only DataMem port. Issues
//               word-aligned accesses, performs read-modify-write for sub-word
//               stores, splits word-crossing accesses into two word accesses,
//               and returns sign/zero-extended load data with a response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // request side
    input  logic            reqValid,
    output logic            reqReady,
    input  logic            reqWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    // response side
    output logic            respValid,
    output logic            respErr,
    output logic [XLEN-1:0] rdata,
    // DataMem port
    output logic [XLEN-1:0] addrIn,
    output logic [XLEN-1:0] dataW,
    input  logic [XLEN-1:0] dataR,
    output logic            memR,
    output logic            memW
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] c_WORD_STEP = XLEN'(4);

    state_t          r_state;
    logic [XLEN-1:0] r_base;
    logic [1:0]      r_off;
    logic [2:0]      r_f3;
    logic            r_write;
    logic [XLEN-1:0] r_wdata;
    logic            r_span;
    logic [XLEN-1:0] r_buf0;
    logic [XLEN-1:0] r_buf1;

    logic [XLEN-1:0]   w_base;
    logic [2:0]        w_size;
    logic              w_span;
    logic              w_illegal;
    logic              w_aligned_sw;
    logic [XLEN-1:0]   w_word0;
    logic [XLEN-1:0]   w_word1;
    logic [2*XLEN-1:0] w_win;
    logic [XLEN-1:0]   w_szmask;
    logic [2*XLEN-1:0] w_ins;
    logic [2*XLEN-1:0] w_msk;
    logic [2*XLEN-1:0] w_mrg;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_load;

    // Decode of the incoming request: size, word-crossing and legality.
    always_comb begin
        w_base = {addr[XLEN-1:2], 2'b00};
        case (funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
        w_span = (({1'b0, addr[1:0]} + w_size) > 3'd4);
        if (reqWrite) begin
            w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        end else begin
            w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                          funct3 == 3'b100 || funct3 == 3'b101);
        end
        w_aligned_sw = reqWrite && (funct3 == 3'b010) && (addr[1:0] == 2'b00);
    end

    // Two-word window seen at the current edge (dataR is live in RD0/RD1), with
    // store bytes merged in and the load bytes extracted from offset off.
    always_comb begin
        w_word0 = (r_state == S_RD0) ? dataR : r_buf0;
        w_word1 = (r_state == S_RD1) ? dataR : r_buf1;
        w_win   = {w_word1, w_word0};
        case (r_f3[1:0])
            2'b00:   w_szmask = XLEN'(32'h0000_00FF);
            2'b01:   w_szmask = XLEN'(32'h0000_FFFF);
            default: w_szmask = {XLEN{1'b1}};
        endcase
        w_ins = {{XLEN{1'b0}}, r_wdata & w_szmask} << {r_off, 3'b000};
        w_msk = {{XLEN{1'b0}}, w_szmask} << {r_off, 3'b000};
        w_mrg = r_write ? ((w_win & ~w_msk) | w_ins) : w_win;
        w_lo  = XLEN'(w_win >> {r_off, 3'b000});
        case (r_f3)
            3'b000:  w_load = {{(XLEN-8){w_lo[7]}}, w_lo[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_lo[15]}}, w_lo[15:0]};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_lo[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_lo[15:0]};
            default: w_load = w_lo;
        endcase
    end

    // Access sequencer; every DataMem and response output is registered on entry to its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            rdata     <= '0;
            addrIn    <= '0;
            dataW     <= '0;
            memR      <= 1'b0;
            memW      <= 1'b0;
            r_base    <= '0;
            r_off     <= '0;
            r_f3      <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_span    <= 1'b0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            respValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        r_base   <= w_base;
                        r_off    <= addr[1:0];
                        r_f3     <= funct3;
                        r_write  <= reqWrite;
                        r_wdata  <= wdata;
                        r_span   <= w_span;
                        r_buf0   <= '0;
                        r_buf1   <= '0;
                        reqReady <= 1'b0;
                        if (w_illegal) begin
                            r_state   <= S_RESP;
                            respValid <= 1'b1;
                            respErr   <= 1'b1;
                            rdata     <= '0;
                        end else if (w_aligned_sw) begin
                            r_state <= S_WR0;
                            addrIn  <= w_base;
                            dataW   <= wdata;
                            memW    <= 1'b1;
                        end else begin
                            r_state <= S_RD0;
                            addrIn  <= w_base;
                            memR    <= 1'b1;
                        end
                    end
                end
                S_RD0: begin
                    r_buf0 <= dataR;
                    if (r_span) begin
                        r_state <= S_RD1;
                        addrIn  <= r_base + c_WORD_STEP;
                    end else if (r_write) begin
                        r_state <= S_WR0;
                        memR    <= 1'b0;
                        memW    <= 1'b1;
                        addrIn  <= r_base;
                        dataW   <= w_mrg[XLEN-1:0];
                    end else begin
                        r_state   <= S_RESP;
                        memR      <= 1'b0;
                        respValid <= 1'b1;
                        respErr   <= 1'b0;
                        rdata     <= w_load;
                    end
                end
                S_RD1: begin
                    // Upper half keeps the merged bytes so WR1 can write it unchanged.
                    r_buf1 <= w_mrg[2*XLEN-1:XLEN];
                    memR   <= 1'b0;
                    if (r_write) begin
                        r_state <= S_WR0;
                        memW    <= 1'b1;
                        addrIn  <= r_base;
                        dataW   <= w_mrg[XLEN-1:0];
                    end else begin
                        r_state   <= S_RESP;
                        respValid <= 1'b1;
                        respErr   <= 1'b0;
                        rdata     <= w_load;
                    end
                end
                S_WR0: begin
                    if (r_span) begin
                        r_state <= S_WR1;
                        addrIn  <= r_base + c_WORD_STEP;
                        dataW   <= r_buf1;
                    end else begin
                        r_state   <= S_RESP;
                        memW      <= 1'b0;
                        respValid <= 1'b1;
                        respErr   <= 1'b0;
                        rdata     <= '0;
                    end
                end
                S_WR1: begin
                    r_state   <= S_RESP;
                    memW      <= 1'b0;
                    respValid <= 1'b1;
                    respErr   <= 1'b0;
                    rdata     <= '0;
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    reqReady <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    reqReady <= 1'b1;
                    memR     <= 1'b0;
                    memW     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed scenarios
//               followed by random loads/stores against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        respValid;
    logic        respErr;
    logic [31:0] rdata;
    logic [31:0] addrIn;
    logic [31:0] dataW;
    logic [31:0] dataR;
    logic        memR;
    logic        memW;

    load_store_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .respValid (respValid),
        .respErr   (respErr),
        .rdata     (rdata),
        .addrIn    (addrIn),
        .dataW     (dataW),
        .dataR     (dataR),
        .memR      (memR),
        .memW      (memW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMem: 16 words, indexed by address bits [5:2] so 0xFFFFFFFC+4 wraps to word 0.
    logic [31:0] mem [16];
    logic        pl_we;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;

    assign dataR = memR ? mem[addrIn[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (memW)       mem[addrIn[5:2]] <= dataW;
        else if (pl_we) mem[pl_idx]      <= pl_val;
    end

    // Bus activity counters sampled mid-cycle.
    int          n_rd;
    int          n_wr;
    int          n_both;
    logic [31:0] last_wr_addr;
    initial begin
        n_rd = 0; n_wr = 0; n_both = 0; last_wr_addr = 32'h0;
    end
    always @(negedge clk) begin
        if (memR) n_rd++;
        if (memW) begin n_wr++; last_wr_addr = addrIn; end
        if (memR && memW) n_both++;
    end

    // Reference memory as bytes; address arithmetic is modulo 64.
    logic [7:0] rb [64];

    int ncmp;
    int nfail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00)      return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else                       return 4;
    endfunction

    function automatic bit is_legal(input logic wr, input logic [2:0] f3);
        if (wr) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int          sz;
        logic [31:0] v;
        sz = size_of(f3);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rb[(int'(a[5:0]) + i) % 64];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = 4'(w); pl_val = v;
        @(posedge clk);
        #1 pl_we = 1'b0;
        for (int i = 0; i < 4; i++) rb[4*w+i] = v[8*i +: 8];
    endtask

    // One request: checks latency, response, bus activity, then updates the model.
    task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] got);
        int   edges;
        int   waitc;
        int   rd0;
        int   wr0;
        int   sz;
        int   off;
        bit   legal;
        bit   span;
        int   exp_lat;
        int   exp_rd;
        int   exp_wr;
        logic [31:0] exp_data;
        sz    = size_of(f3);
        off   = int'(a[1:0]);
        legal = is_legal(wr, f3);
        span  = (off + sz) > 4;
        if (!legal) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!wr) begin
            exp_lat = span ? 3 : 2; exp_rd = span ? 2 : 1; exp_wr = 0;
        end else if (sz == 4 && off == 0) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
        end else begin
            exp_lat = span ? 5 : 3; exp_rd = span ? 2 : 1; exp_wr = span ? 2 : 1;
        end
        exp_data = (legal && !wr) ? ref_load(a, f3) : 32'h0;

        @(negedge clk);
        waitc = 0;
        while (!reqReady && waitc < 20) begin @(negedge clk); waitc++; end
        chk("ready_before_req", 32'(reqReady), 32'h1);
        reqValid = 1'b1; reqWrite = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        rd0 = n_rd; wr0 = n_wr; edges = 1;
        @(negedge clk);
        reqValid = 1'b0;
        while (!respValid && edges < 12) begin
            @(posedge clk); edges++;
            @(negedge clk);
        end
        got = rdata;
        chk("resp_seen", 32'(respValid), 32'h1);
        chk("latency", 32'(edges), 32'(exp_lat));
        chk("respErr", 32'(respErr), legal ? 32'h0 : 32'h1);
        if (!wr || !legal) chk("rdata", rdata, exp_data);
        chk("memR_cycles", 32'(n_rd - rd0), 32'(exp_rd));
        chk("memW_cycles", 32'(n_wr - wr0), 32'(exp_wr));
        @(negedge clk);
        chk("resp_pulse_end", 32'(respValid), 32'h0);
        chk("ready_after_resp", 32'(reqReady), 32'h1);
        if (wr && legal) begin
            for (int i = 0; i < sz; i++) rb[(int'(a[5:0]) + i) % 64] = wd[8*i +: 8];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] r;

    initial begin
        ncmp = 0; nfail = 0;
        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; funct3 = 3'd0;
        addr = 32'h0; wdata = 32'h0;
        pl_we = 1'b0; pl_idx = 4'd0; pl_val = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reqReady", 32'(reqReady), 32'h1);
        chk("rst_respValid", 32'(respValid), 32'h0);
        chk("rst_respErr", 32'(respErr), 32'h0);
        chk("rst_memR", 32'(memR), 32'h0);
        chk("rst_memW", 32'(memW), 32'h0);
        chk("rst_addrIn", addrIn, 32'h0);
        chk("rst_dataW", dataW, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        for (int w = 0; w < 16; w++) set_word(w, $urandom);
        set_word(0, 32'ha28b538c);
        set_word(1, 32'h11223344);

        // Byte loads, signed and unsigned.
        run_req(1'b0, 3'b000, 32'h3, 32'h0, r); chk("tp_lb", r, 32'hffffffa2);
        chk("tp_lb_addr", addrIn, 32'h0);
        run_req(1'b0, 3'b100, 32'h3, 32'h0, r); chk("tp_lbu", r, 32'h000000a2);
        // Word-crossing loads.
        run_req(1'b0, 3'b001, 32'h3, 32'h0, r); chk("tp_lh_span", r, 32'h000044a2);
        chk("tp_lh_addr2", addrIn, 32'h4);
        run_req(1'b0, 3'b010, 32'h2, 32'h0, r); chk("tp_lw_span", r, 32'h3344a28b);
        // Byte store read-modify-write.
        run_req(1'b1, 3'b000, 32'h1, 32'h000000ff, r);
        chk("tp_sb_mem", mem[0], 32'ha28bff8c);
        run_req(1'b0, 3'b010, 32'h0, 32'h0, r); chk("tp_lw_after_sb", r, 32'ha28bff8c);
        // Spanning halfword store.
        set_word(0, 32'ha28b538c);
        set_word(1, 32'h11223344);
        run_req(1'b1, 3'b001, 32'h3, 32'h0000beef, r);
        chk("tp_sh_w0", mem[0], 32'hef8b538c);
        chk("tp_sh_w1", mem[1], 32'h112233be);
        // Aligned word store and an illegal load.
        run_req(1'b1, 3'b010, 32'h8, 32'hdeadbeef, r);
        chk("tp_sw_mem", mem[2], 32'hdeadbeef);
        chk("tp_sw_addr", last_wr_addr, 32'h8);
        run_req(1'b0, 3'b011, 32'h4, 32'h0, r);
        run_req(1'b1, 3'b100, 32'h4, 32'h0, r);
        // Address wrap: halfword at 0xFFFFFFFF covers word 15 byte 3 and word 0 byte 0.
        run_req(1'b0, 3'b101, 32'hffffffff, 32'h0, r);

        // Reset during the second read of a spanning load.
        set_word(1, 32'h11223344);
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; funct3 = 3'b010; addr = 32'h2;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        chk("abort_rd0_memR", 32'(memR), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_rd1_addr", addrIn, 32'h4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_memR", 32'(memR), 32'h0);
        chk("abort_reqReady", 32'(reqReady), 32'h1);
        chk("abort_respValid", 32'(respValid), 32'h0);
        @(negedge clk);
        chk("abort_no_resp", 32'(respValid), 32'h0);
        run_req(1'b0, 3'b010, 32'h4, 32'h0, r); chk("abort_lw_after", r, 32'h11223344);

        // Random traffic against the byte model.
        for (int k = 0; k < 150; k++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, r);
        end
        for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_word(w));
        chk("no_rd_wr_overlap", 32'(n_both), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
